// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: load func3 encodings and FSM states.
package writeback_stage_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitLoad = 2'd1,
        StDrain    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_data_formatter.sv
// Combinational load-data alignment and extension; flags misaligned or illegal loads.
module load_data_formatter
    import writeback_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_type,
    output logic [31:0] data,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/halfword from the little-endian word.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend according to load type; unknown types and misaligned accesses are illegal.
    always_comb begin
        data    = 32'h0;
        illegal = 1'b0;
        case (load_type)
            LT_LB: begin
                data = {{24{byte_sel[7]}}, byte_sel};
            end
            LT_LBU: begin
                data = {24'h0, byte_sel};
            end
            LT_LH: begin
                data    = {{16{half_sel[15]}}, half_sel};
                illegal = addr_lo[0];
            end
            LT_LHU: begin
                data    = {16'h0, half_sel};
                illegal = addr_lo[0];
            end
            LT_LW: begin
                data    = rdata;
                illegal = (addr_lo != 2'd0);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires instructions into the register file, waiting on
// variable-latency load responses with flush, timeout and misalignment handling.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wb_reg_file,
    input  logic        in_wb_load,
    input  logic [2:0]  in_mem_load_type,
    input  logic [1:0]  in_addr_lo,
    input  logic [31:0] in_alu_result,
    input  logic        flush,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        reg_file_wr_en,
    output logic [4:0]  reg_file_wr_addr,
    output logic [31:0] reg_file_wr_data,
    output logic        err_misaligned,
    output logic        err_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(RESP_TIMEOUT);

    wb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [4:0]        lat_rd_q;
    logic              lat_wb_q;
    logic [2:0]        lat_type_q;
    logic [1:0]        lat_addr_q;
    logic              accept_load;
    logic              wr_en_q, wr_en_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              err_mis_q, err_mis_d;
    logic              err_to_q, err_to_d;
    logic [31:0]       fmt_data;
    logic              fmt_illegal;

    // Formatting uses the fields latched at accept, so the check reflects accept-time info.
    load_data_formatter u_fmt (
        .rdata     (dmem_rdata),
        .addr_lo   (lat_addr_q),
        .load_type (lat_type_q),
        .data      (fmt_data),
        .illegal   (fmt_illegal)
    );

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state, write-port and handshake logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_mis_d   = err_mis_q;
        err_to_d    = err_to_q;
        in_ready    = 1'b0;
        accept_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = !flush;
                if (in_valid && !flush) begin
                    if (in_wb_load) begin
                        accept_load = 1'b1;
                        cnt_d       = '0;
                        state_d     = StWaitLoad;
                    end else begin
                        wr_en_d   = in_wb_reg_file && (in_rd != 5'd0);
                        wr_addr_d = in_rd;
                        wr_data_d = in_alu_result;
                    end
                end
            end
            StWaitLoad: begin
                if (dmem_rvalid) begin
                    state_d = StIdle;
                    // A flush coinciding with the response drops the write entirely.
                    if (!flush) begin
                        if (fmt_illegal) begin
                            err_mis_d = 1'b1;
                        end else begin
                            wr_en_d   = lat_wb_q && (lat_rd_q != 5'd0);
                            wr_addr_d = lat_rd_q;
                            wr_data_d = fmt_data;
                        end
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        err_to_d = 1'b1;
                        state_d  = StIdle;
                    end else if (flush) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (dmem_rvalid) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        err_to_d = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter, write port and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'h0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_mis_q <= err_mis_d;
            err_to_q  <= err_to_d;
        end
    end

    // Capture the load's destination and format info when it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_rd_q   <= 5'd0;
            lat_wb_q   <= 1'b0;
            lat_type_q <= 3'd0;
            lat_addr_q <= 2'd0;
        end else if (accept_load) begin
            lat_rd_q   <= in_rd;
            lat_wb_q   <= in_wb_reg_file;
            lat_type_q <= in_mem_load_type;
            lat_addr_q <= in_addr_lo;
        end
    end

    assign reg_file_wr_en   = wr_en_q;
    assign reg_file_wr_addr = wr_addr_q;
    assign reg_file_wr_data = wr_data_q;
    assign err_misaligned   = err_mis_q;
    assign err_timeout      = err_to_q;

endmodule
